// File: rtl/mem_bist_master.sv
// Memory BIST bus initiator: writes seed+i to a word block, reads it back,
// and reports pass, error count and first failing address.
module mem_bist_master #(
  parameter int WIDTH   = 32,
  parameter int CNTBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   base,
  input  logic [CNTBITS-1:0] nwords,
  input  logic [WIDTH-1:0]   seed,
  input  logic [WIDTH-1:0]   memdata,
  output logic               memread,
  output logic               memwrite,
  output logic [WIDTH-1:0]   adr,
  output logic [WIDTH-1:0]   writedata,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNTBITS-1:0] errcount,
  output logic [WIDTH-1:0]   firstfail
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNTBITS-1:0] r_n;
  logic [CNTBITS-1:0] r_i;
  logic [WIDTH-1:0]   r_base;
  logic [WIDTH-1:0]   r_seed;
  logic [WIDTH-1:0]   r_pat;

  logic             w_last;
  logic             w_miss;
  logic             w_sat;
  logic [WIDTH-1:0] w_base;

  assign w_base = {base[WIDTH-1:2], 2'b00};
  assign w_last = (r_i == r_n - CNTBITS'(1));
  assign w_miss = (memdata != r_pat);
  assign w_sat  = &errcount;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_i       <= '0;
      r_base    <= '0;
      r_seed    <= '0;
      r_pat     <= '0;
      memread   <= 1'b0;
      memwrite  <= 1'b0;
      adr       <= '0;
      writedata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      errcount  <= '0;
      firstfail <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base    <= w_base;
            r_n       <= nwords;
            r_seed    <= seed;
            r_i       <= '0;
            errcount  <= '0;
            firstfail <= '0;
            if (nwords != '0) begin
              pass      <= 1'b0;
              busy      <= 1'b1;
              memwrite  <= 1'b1;
              adr       <= w_base;
              writedata <= seed;
              r_state   <= S_WRITE;
            end else begin
              pass    <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          if (w_last) begin
            memwrite <= 1'b0;
            memread  <= 1'b1;
            adr      <= r_base;
            r_pat    <= r_seed;
            r_i      <= '0;
            r_state  <= S_READ;
          end else begin
            r_i       <= r_i + CNTBITS'(1);
            adr       <= adr + WIDTH'(4);
            writedata <= writedata + WIDTH'(1);
          end
        end
        S_READ: begin
          // errcount==0 before this compare marks the first mismatch
          if (w_miss) begin
            if (!w_sat) errcount <= errcount + CNTBITS'(1);
            if (errcount == '0) firstfail <= adr;
          end
          if (w_last) begin
            memread <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= !w_miss && (errcount == '0);
            r_state <= S_DONE;
          end else begin
            r_i   <= r_i + CNTBITS'(1);
            adr   <= adr + WIDTH'(4);
            r_pat <= r_pat + WIDTH'(1);
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bist_master.md
# mem_bist_master

Bus initiator for the 32-bit external-memory interface used by `mips32`: drives `memread`/`memwrite`/`adr`/`writedata` and samples `memdata`, exactly as the processor does toward `exmemory`. On a `start` pulse it writes an incrementing pattern to a block of word addresses, reads the block back, and compares. It reports pass/fail, the error count and the first failing address. It sits beside or in place of `mips32` on the memory port, for memory bring-up and for post-P&R testbenches.

## Interface
- `WIDTH`, 32, data and address width; addresses are byte addresses, word-aligned.
- `CNTBITS`, 8, width of the word-count and error-count fields (max 255 words, matching the 256-word memory).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; `reset`=0 forces the reset state immediately.
- `start`  in  1  one-cycle request, sampled only in IDLE.
- `base`  in  WIDTH  start byte address; bits [1:0] ignored (treated as 0); latched at start.
- `nwords`  in  CNTBITS  number of words to test; latched at start.
- `seed`  in  WIDTH  pattern seed; latched at start.
- `memdata`  in  WIDTH  read data from memory; combinational on `adr`.
- `memread`  out  1  read strobe.
- `memwrite`  out  1  write strobe; memory captures `writedata` at the next rising edge.
- `adr`  out  WIDTH  byte address.
- `writedata`  out  WIDTH  write data.
- `busy`  out  1  high in WRITE and READ.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  1 when the last run had zero mismatches; held until the next start.
- `errcount`  out  CNTBITS  mismatch count of the last run; saturates at all-ones.
- `firstfail`  out  WIDTH  address of the first mismatch in the last run; 0 if none.

## Operation
- All outputs are registered. Reset values: `memread`=0, `memwrite`=0, `adr`=0, `writedata`=0, `busy`=0, `done`=0, `pass`=0, `errcount`=0, `firstfail`=0. The state is IDLE.
- Pattern: word i (0 ≤ i < N) has data P(i) = `seed` + i, modulo 2^WIDTH. Its address is A(i) = {`base`[WIDTH-1:2],2'b00} + 4·i, modulo 2^WIDTH. The address wraps past all-ones to 0.
- States:
  - IDLE: on `start`=1, latch `base`, `nwords`, `seed`; clear `errcount`, `firstfail`, `pass`. Go to WRITE if N>0, else go to DONE.
  - WRITE: drive `memwrite`=1, `adr`=A(i), `writedata`=P(i) for i=0..N-1, one word per cycle. After i=N-1, go to READ with i=0.
  - READ: drive `memread`=1, `adr`=A(i) for i=0..N-1. At the closing rising edge of each cycle, compare `memdata` with P(i).
    - On mismatch, `errcount` increments, saturating at all-ones.
    - On the first mismatch only, `firstfail` is set to A(i).
    - After i=N-1, go to DONE.
  - DONE: `done`=1 for exactly one cycle. `pass`=(`errcount`==0), including the effect of the final comparison. `busy`=0. Return to IDLE.
- `memread` and `memwrite` are never 1 in the same cycle. Both are 0 in IDLE and DONE. `writedata` holds its last value when not writing.
- `start` while not in IDLE is ignored. `start` held high causes back-to-back runs, with one IDLE cycle between DONE and the next WRITE.
- Reset (`reset`=0) mid-run aborts at once: all outputs return to their reset values and no partial result is reported. Memory contents already written are not restored.
- A zero-length run (N=0) produces no bus activity: `done` pulses with `pass`=1, `errcount`=0.

## Timing
- `start` sampled high at edge t0 → `busy`=1, `memwrite`=1, `adr`=A(0) in the cycle after t0.
- Write i occupies cycle t0+1+i. The memory captures it at the end of that cycle.
- Read i occupies cycle t0+1+N+i. The compare happens at edge t0+2+N+i.
- `done` is high during cycle t0+1+2N. The total is 2N+1 cycles from start to the done pulse.
- Read data must be valid within the same cycle as `adr` (combinational memory). No wait states are supported.
- Write-then-read ordering: read of word 0 starts N cycles after its write. Word 0 is the only word read one cycle after the last write (when N=1), and the memory model's posedge write makes this legal.

## Test plan
- `base`=0x10, `nwords`=4, `seed`=7 → writes 7,8,9,10 to addresses 0x10,0x14,0x18,0x1C in cycles 1–4. Reads in cycles 5–8, `done` in cycle 9, `pass`=1, `errcount`=0, `firstfail`=0.
- Same run, with the bench forcing `memdata` to 0 during the read of 0x14 and 0x1C → `pass`=0, `errcount`=2, `firstfail`=0x14.
- `nwords`=0 → `done` in the cycle after start, no `memread`/`memwrite` ever high, `pass`=1.
- `base`=0xFFFFFFFC, `nwords`=2, `seed`=0xFFFFFFFF → writes 0xFFFFFFFF at 0xFFFFFFFC and 0x00000000 at 0x00000000 (both address and data wrap). `base`=0x13 behaves as 0x10.
- `reset` driven low during the third write of an 8-word run → all outputs 0 asynchronously, `done` never pulses. A new start after release runs cleanly from i=0.
- `start` pulsed mid-run, and all 255 reads forced wrong → the mid-run start is ignored, `errcount`=255 saturates, `pass`=0.
